// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with a final sign-fix cycle.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            r_state;
   logic [2:0]        r_op;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_dvs;
   logic [XLEN-1:0]   r_rem;
   logic              r_neg;
   logic              r_special;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   logic              w_sgn_a;
   logic              w_sgn_b;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_abs;
   logic [XLEN-1:0]   w_b_abs;
   logic              w_neg_res;
   logic              w_div0;
   logic              w_ovf;
   logic [XLEN-1:0]   w_spec_val;
   logic [XLEN-1:0]   w_madd;
   logic [XLEN:0]     w_msum;
   logic [2*XLEN-1:0] w_mul_next;
   logic [XLEN:0]     w_shift;
   logic              w_ge;
   logic [XLEN-1:0]   w_sub;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_remv;
   logic [XLEN-1:0]   w_fix_res;

   // Operand sign handling: MULH/DIV/REM sign both, MULHSU signs only a
   assign w_sgn_a = (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b110);
   assign w_sgn_b = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign w_a_neg = w_sgn_a & a[XLEN-1];
   assign w_b_neg = w_sgn_b & b[XLEN-1];
   assign w_a_abs = w_a_neg ? -a : a;
   assign w_b_abs = w_b_neg ? -b : b;
   assign w_neg_res = (funct3[2] & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

   assign w_div0 = funct3[2] & (b == {XLEN{1'b0}});
   assign w_ovf  = funct3[2] & ~funct3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) &
                   (b == {XLEN{1'b1}});
   assign w_spec_val = w_div0 ? (funct3[1] ? a : {XLEN{1'b1}})
                              : (funct3[1] ? {XLEN{1'b0}} : a);

   // Multiply step: add multiplicand into the high half, shift right by one
   assign w_madd     = r_acc[0] ? r_dvs : {XLEN{1'b0}};
   assign w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_madd};
   assign w_mul_next = {w_msum, r_acc[XLEN-1:1]};

   // Divide step: quotient bits shift into r_acc low half as dividend bits leave
   assign w_shift = {r_rem, r_acc[XLEN-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_sub   = w_shift[XLEN-1:0] - r_dvs;

   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_remv = r_neg ? -r_rem : r_rem;

   // Final result selection in the FIX cycle
   always_comb begin
      w_fix_res = {XLEN{1'b0}};
      if (r_special) begin
         w_fix_res = r_acc[XLEN-1:0];
      end else begin
         case (r_op)
            3'b000:                w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:        w_fix_res = w_quo;
            3'b110, 3'b111:        w_fix_res = w_remv;
            default:               w_fix_res = {XLEN{1'b0}};
         endcase
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_op      <= 3'b000;
         r_cnt     <= {CW{1'b0}};
         r_acc     <= {(2*XLEN){1'b0}};
         r_dvs     <= {XLEN{1'b0}};
         r_rem     <= {XLEN{1'b0}};
         r_neg     <= 1'b0;
         r_special <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= {XLEN{1'b0}};
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_op  <= funct3;
                     r_neg <= w_neg_res;
                     r_dvs <= w_b_abs;
                     r_rem <= {XLEN{1'b0}};
                     r_cnt <= CW'(XLEN);
                     if (w_div0 | w_ovf) begin
                        r_special <= 1'b1;
                        r_acc     <= {{XLEN{1'b0}}, w_spec_val};
                        r_state   <= S_FIX;
                     end else begin
                        r_special <= 1'b0;
                        r_acc     <= {{XLEN{1'b0}}, w_a_abs};
                        r_state   <= S_CALC;
                     end
                  end
               end
               S_CALC: begin
                  r_cnt <= r_cnt - CW'(1);
                  if (r_op[2]) begin
                     r_rem             <= w_ge ? w_sub : w_shift[XLEN-1:0];
                     r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], w_ge};
                  end else begin
                     r_acc <= w_mul_next;
                  end
                  if (r_cnt == CW'(1)) begin
                     r_state <= S_FIX;
                  end
               end
               S_FIX: begin
                  r_result <= w_fix_res;
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=32): latency, results, handshake, flush, reset.
module tb_mdu_iter;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            flush = 1'b0;
   logic [2:0]      funct3 = 3'b000;
   logic [XLEN-1:0] a = 32'd0;
   logic [XLEN-1:0] b = 32'd0;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int n_cmp = 0;
   int n_err = 0;

   mdu_iter #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Present an op for one edge; called and returns at a negedge.
   task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
      funct3 = op; a = va; b = vb; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count edges after the accepting edge until done is seen; -1 on timeout.
   task automatic wait_done(output int edges);
      bit seen = 1'b0;
      edges = 0;
      while (!seen && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) edges = -1;
   endtask

   task automatic test_reset_init();
      #12;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      logic [2:0]  op [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
      logic [31:0] va [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] vb [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(op[i], va[i], vb[i]);
         wait_done(lat);
         n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul%0d_latency: got %0d expected 33", i, lat); end
         n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL mul%0d_result: got %h expected %h", i, result, ex[i]); end
      end
   endtask

   task automatic test_div();
      logic [2:0]  op [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] vb [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(op[i], va[i], vb[i]);
         wait_done(lat);
         n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div%0d_latency: got %0d expected 33", i, lat); end
         n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL div%0d_result: got %h expected %h", i, result, ex[i]); end
      end
   endtask

   task automatic test_special();
      logic [2:0]  op [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
      logic [31:0] va [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(op[i], va[i], vb[i]);
         wait_done(lat);
         n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL special%0d_latency: got %0d expected 1", i, lat); end
         n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL special%0d_result: got %h expected %h", i, result, ex[i]); end
      end
   endtask

   task automatic test_busy_start();
      int ndone = 0;
      logic [31:0] res_at_done = 32'd0;
      issue(3'b000, 32'd5, 32'd6);
      repeat (5) @(negedge clk);
      funct3 = 3'b000; a = 32'd100; b = 32'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin ndone++; res_at_done = result; end
      end
      n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL busy_start_dones: got %0d expected 1", ndone); end
      n_cmp++; if (res_at_done !== 32'd30) begin n_err++; $display("FAIL busy_start_result: got %h expected %h", res_at_done, 32'd30); end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(3'b101, 32'd100, 32'd7);
      wait_done(lat);
      n_cmp++; if (result !== 32'd14) begin n_err++; $display("FAIL b2b_first_result: got %h expected %h", result, 32'd14); end
      issue(3'b000, 32'd7, 32'hFFFF_FFFD);
      wait_done(lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
      n_cmp++; if (result !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL b2b_second_result: got %h expected %h", result, 32'hFFFF_FFEB); end
   endtask

   task automatic test_flush();
      int ndone = 0;
      int lat;
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy); end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL flush_no_done: got %0d expected 0", ndone); end
      n_cmp++; if (result !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL flush_result_kept: got %h expected %h", result, 32'hFFFF_FFEB); end
      funct3 = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_ignored: got %b expected 0", busy); end
      issue(3'b000, 32'd3, 32'd4);
      wait_done(lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL post_flush_latency: got %0d expected 33", lat); end
      n_cmp++; if (result !== 32'd12) begin n_err++; $display("FAIL post_flush_result: got %h expected %h", result, 32'd12); end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      issue(3'b100, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b expected 0", done); end
      n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL midreset_result: got %h expected 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL midreset_no_done: got %0d expected 0", ndone); end
   endtask

   initial begin
      test_reset_init();
      test_mul();
      test_div();
      test_special();
      test_busy_start();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
